// File: rtl/scp_pkg.sv
// scp_pkg: shared constants and types for the instruction fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Build macro SCP_PREFETCH_EN selects a 4-entry prefetch queue (default is 1 entry).
package scp_pkg;

   localparam int WORD_W = 16;
   typedef logic [WORD_W-1:0] word_t;

   localparam word_t RESET_VEC = 16'h0000;

   localparam int PREFETCH_DEPTH_ON  = 4;
   localparam int PREFETCH_DEPTH_OFF = 1;

`ifdef SCP_PREFETCH_EN
   localparam int FETCH_DEPTH = PREFETCH_DEPTH_ON;
`else
   localparam int FETCH_DEPTH = PREFETCH_DEPTH_OFF;
`endif

   // Occupancy counter must represent 0..FETCH_DEPTH inclusive.
   localparam int CNT_W = $clog2(FETCH_DEPTH + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t DEPTH_CNT = cnt_t'(FETCH_DEPTH);

   typedef struct packed {
      word_t data;
      word_t pc;
   } fq_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {data, pc} store between memory returns and the decoder.
// Latency: a push is visible at head on the following cycle (registered, no bypass).
// Backpressure: full blocks push unless a pop frees the slot in the same cycle; flush wins over push/pop.
// Ports: clk, rst (sync, active-high); push/push_entry, pop, flush in; full, empty, count, head out.
// Build macro SCP_PREFETCH_EN: 4-entry circular buffer; otherwise a single holding register.
module fetch_queue
   import scp_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  fq_entry_t push_entry,
   input  logic      pop,
   input  logic      flush,
   output logic      full,
   output logic      empty,
   output cnt_t      count,
   output fq_entry_t head
);

   logic do_push;
   logic do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

`ifdef SCP_PREFETCH_EN
   fq_entry_t  slots [FETCH_DEPTH];
   logic [1:0] rd_ptr;
   logic [1:0] wr_ptr;
   cnt_t       cnt;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= 2'd0;
         wr_ptr <= 2'd0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 2'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
         cnt <= cnt + cnt_t'(do_push) - cnt_t'(do_pop);
      end
   end

   // Storage is not reset; head is masked while empty instead.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) slots[wr_ptr] <= push_entry;
   end

   assign full  = (cnt == DEPTH_CNT);
   assign empty = (cnt == '0);
   assign count = cnt;
   assign head  = empty ? '0 : slots[rd_ptr];
`else
   fq_entry_t hold;
   logic      hold_vld;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         hold_vld <= 1'b0;
      end else if (do_push) begin
         hold_vld <= 1'b1;
      end else if (do_pop) begin
         hold_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) hold <= push_entry;
   end

   assign full  = hold_vld;
   assign empty = !hold_vld;
   assign count = hold_vld;
   assign head  = hold_vld ? hold : '0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher feeding a decoder through fetch_queue.
// Latency: mem_ack at cycle M -> ir_valid at M+1; redirect with nothing outstanding -> mem_req at N+1.
// Backpressure: no request while the queue is full; decoder pops with ir_valid && ir_ready.
// Ports: clk, rst (sync, active-high); redirect/redirect_addr; mem_req/mem_addr/mem_ack/mem_data;
//        ir_valid/ir_data/ir_pc/ir_ready. Build macro SCP_PREFETCH_EN enables the 4-deep queue.
module fetch_unit
   import scp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_addr,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_data,
   output logic              ir_valid,
   output logic [WORD_W-1:0] ir_data,
   output logic [WORD_W-1:0] ir_pc,
   input  logic              ir_ready
);

   localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W+1)'(FETCH_DEPTH);

   fetch_state_t   state_q;
   fetch_state_t   state_d;
   word_t          fpc_q;
   word_t          fpc_d;
   word_t          addr_q;
   word_t          addr_d;
   logic           q_push;
   logic           q_pop;
   logic           q_full;
   logic           q_empty;
   cnt_t           q_count;
   fq_entry_t      q_head;
   fq_entry_t      q_in;
   logic [CNT_W:0] cnt_after;
   logic           room_after;

   // A redirect flushes the queue, so a coincident pop has no separate effect.
   assign q_pop = ir_valid && ir_ready && !redirect;
   assign q_in  = '{data: mem_data, pc: fpc_q};

   // Occupancy after this cycle's push (ack in REQ) and pop; decides back-to-back issue.
   assign cnt_after  = {1'b0, q_count} + (CNT_W+1)'(1) - (CNT_W+1)'(q_pop);
   assign room_after = (cnt_after < DEPTH_EXT);

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      addr_d  = addr_q;
      q_push  = 1'b0;
      case (state_q)
         IDLE: begin
            // Redirect issues straight to the new target so the request is out next cycle;
            // the flush guarantees room. Any mem_ack seen here is stale and ignored.
            if (redirect) begin
               fpc_d   = redirect_addr;
               addr_d  = redirect_addr;
               state_d = REQ;
            end else if (!q_full) begin
               addr_d  = fpc_q;
               state_d = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               fpc_d   = redirect_addr;
               // Ack in the same cycle: data discarded, request already done.
               // Otherwise the old request must still be retired in DROP.
               state_d = mem_ack ? IDLE : DROP;
            end else if (mem_ack) begin
               q_push = 1'b1;
               fpc_d  = fpc_q + 16'd1;
               if (room_after) begin
                  addr_d  = fpc_q + 16'd1;
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (redirect) fpc_d = redirect_addr;
            if (mem_ack)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         fpc_q   <= RESET_VEC;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         addr_q  <= addr_d;
      end
   end

   fetch_queue u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (q_push),
      .push_entry (q_in),
      .pop        (q_pop),
      .flush      (redirect),
      .full       (q_full),
      .empty      (q_empty),
      .count      (q_count),
      .head       (q_head)
   );

   assign mem_req  = (state_q != IDLE);
   assign mem_addr = addr_q;
   assign ir_valid = !q_empty;
   assign ir_data  = q_head.data;
   assign ir_pc    = q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a latency-programmable memory model
// and a scoreboard of expected {data, pc} pairs pushed on accepted acks and popped on decoder pops.
// Works with and without SCP_PREFETCH_EN (expected depth follows the macro).
module tb_fetch_unit;

   localparam logic [15:0] KEY = 16'h5A3C;

`ifdef SCP_PREFETCH_EN
   localparam int EXP_DEPTH = 4;
`else
   localparam int EXP_DEPTH = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [15:0] redirect_addr;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic        ir_valid;
   logic [15:0] ir_data;
   logic [15:0] ir_pc;
   logic        ir_ready;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .ir_valid      (ir_valid),
      .ir_data       (ir_data),
      .ir_pc         (ir_pc),
      .ir_ready      (ir_ready)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [15:0] pc;
   } exp_t;

   typedef struct {
      logic [15:0] target;
      int          lat;
      logic [15:0] a0;
      logic [15:0] a1;
      logic [15:0] a2;
   } vec_t;

   exp_t        exp_q [$];
   logic [15:0] issued [$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          mem_lat = 1;
   int          mcnt    = 0;
   int          push_cnt = 0;
   bit          force_ack = 0;
   bit          stale = 0;
   bit          vld_expect = 0;
   bit          first_seen = 0;
   logic [15:0] first_pc = 16'h0;
   vec_t        vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Memory model: acks after mem_lat cycles of a visible request.
   task automatic mem_drive();
      mem_ack  = 1'b0;
      mem_data = 16'h0000;
      if (force_ack) begin
         mem_ack   = 1'b1;
         mem_data  = 16'hDEAD;
         force_ack = 0;
         mcnt      = 0;
      end else if (mem_req === 1'b1) begin
         if (mcnt >= mem_lat) begin
            mem_ack  = 1'b1;
            mem_data = mem_addr ^ KEY;
            mcnt     = 0;
         end else begin
            mcnt++;
         end
      end else begin
         mcnt = 0;
      end
   endtask

   // Scoreboard update for the current cycle, then advance to just after the next edge.
   task automatic finish_cycle();
      logic acc;
      exp_t e;
      acc = 1'b0;
      if (rst) begin
         exp_q.delete();
         stale      = 0;
         vld_expect = 0;
         first_seen = 0;
      end else begin
         if (vld_expect) chk("ack_to_ir_valid", {31'd0, ir_valid}, 32'd1);
         vld_expect = 0;
         acc = mem_ack && mem_req && !stale && !redirect;
         if (mem_ack && mem_req) stale = 0;
         if (redirect) begin
            if (mem_req && !mem_ack) stale = 1;
            exp_q.delete();
            first_seen = 0;
         end else if (ir_valid && ir_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL pop_unexpected: got pc 0x%0h, expected no output", ir_pc);
            end else begin
               e = exp_q.pop_front();
               chk("ir_data", {16'd0, ir_data}, {16'd0, e.data});
               chk("ir_pc", {16'd0, ir_pc}, {16'd0, e.pc});
            end
            if (!first_seen) begin
               first_seen = 1;
               first_pc   = ir_pc;
            end
         end
         if (acc) begin
            exp_q.push_back('{data: mem_data, pc: mem_addr});
            issued.push_back(mem_addr);
            push_cnt++;
            vld_expect = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      mem_drive();
      finish_cycle();
   endtask

   task automatic apply_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      issued.delete();
   endtask

   initial begin
      bit hit;

      vecs[0] = '{target: 16'h1234, lat: 3, a0: 16'h1234, a1: 16'h1235, a2: 16'h1236};
      vecs[1] = '{target: 16'hFFFE, lat: 1, a0: 16'hFFFE, a1: 16'hFFFF, a2: 16'h0000};
      vecs[2] = '{target: 16'h00FF, lat: 2, a0: 16'h00FF, a1: 16'h0100, a2: 16'h0101};
      vecs[3] = '{target: 16'h8000, lat: 1, a0: 16'h8000, a1: 16'h8001, a2: 16'h8002};

      rst           = 1'b1;
      redirect      = 1'b0;
      redirect_addr = 16'h0000;
      ir_ready      = 1'b1;
      mem_ack       = 1'b0;
      mem_data      = 16'h0000;
      #1;
      cyc();
      cyc();
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_ir_data", {16'd0, ir_data}, 32'd0);
      chk("rst_ir_pc", {16'd0, ir_pc}, 32'd0);
      rst = 1'b0;
      issued.delete();

      // Sequential fetch from the reset vector.
      for (int k = 0; k < 100 && issued.size() < 3; k++) cyc();
      if (issued.size() < 3) timeout("seq_fetch");
      else begin
         chk("seq_addr0", {16'd0, issued[0]}, 32'h0000);
         chk("seq_addr1", {16'd0, issued[1]}, 32'h0001);
         chk("seq_addr2", {16'd0, issued[2]}, 32'h0002);
      end

      // Redirect vectors: first three fetched addresses and first delivered pc.
      for (int v = 0; v < 4; v++) begin
         mem_lat = vecs[v].lat;
         for (int k = 0; k < 50 && !mem_req; k++) cyc();
         if (!mem_req) timeout("vec_wait_req");
         redirect      = 1'b1;
         redirect_addr = vecs[v].target;
         issued.delete();
         cyc();
         redirect = 1'b0;
         for (int k = 0; k < 300 && !(issued.size() >= 3 && first_seen); k++) cyc();
         if (issued.size() < 3 || !first_seen) timeout("vec_fetch");
         else begin
            chk("vec_addr0", {16'd0, issued[0]}, {16'd0, vecs[v].a0});
            chk("vec_addr1", {16'd0, issued[1]}, {16'd0, vecs[v].a1});
            chk("vec_addr2", {16'd0, issued[2]}, {16'd0, vecs[v].a2});
            chk("vec_first_pc", {16'd0, first_pc}, {16'd0, vecs[v].target});
         end
      end

      // Full queue: decoder stalled, exactly depth requests, then one pop -> one more.
      mem_lat = 1;
      apply_reset();
      ir_ready = 1'b0;
      push_cnt = 0;
      for (int k = 0; k < 40; k++) cyc();
      chk("full_fetch_count", push_cnt, EXP_DEPTH);
      chk("full_mem_req_off", {31'd0, mem_req}, 32'd0);
      ir_ready = 1'b1;
      cyc();
      ir_ready = 1'b0;
      for (int k = 0; k < 20; k++) cyc();
      chk("pop_refill_count", push_cnt, EXP_DEPTH + 1);
      chk("pop_refill_req_off", {31'd0, mem_req}, 32'd0);

      // Redirect coinciding with mem_ack and (when the queue holds data) an ir pop.
      apply_reset();
      ir_ready = 1'b0;
      hit = 0;
      for (int k = 0; k < 100 && !hit; k++) begin
         mem_drive();
         if (mem_ack && (ir_valid || EXP_DEPTH == 1)) begin
            hit           = 1;
            redirect      = 1'b1;
            redirect_addr = 16'h4000;
            ir_ready      = 1'b1;
            issued.delete();
         end
         finish_cycle();
         redirect = 1'b0;
      end
      if (!hit) timeout("coincide_wait");
      else begin
         chk("coincide_flush", {31'd0, ir_valid}, 32'd0);
         for (int k = 0; k < 100 && !(issued.size() >= 1 && first_seen); k++) cyc();
         if (issued.size() < 1 || !first_seen) timeout("coincide_restart");
         else begin
            chk("coincide_addr", {16'd0, issued[0]}, 32'h4000);
            chk("coincide_pc", {16'd0, first_pc}, 32'h4000);
         end
      end

      // Reset during REQ, then a stale ack while idle.
      mem_lat  = 3;
      ir_ready = 1'b1;
      apply_reset();
      for (int k = 0; k < 20 && !mem_req; k++) cyc();
      if (!mem_req) timeout("rstreq_wait");
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      issued.delete();
      chk("rstreq_req_off", {31'd0, mem_req}, 32'd0);
      force_ack = 1;
      cyc();
      chk("stale_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("stale_restart_req", {31'd0, mem_req}, 32'd1);
      chk("stale_restart_addr", {16'd0, mem_addr}, 32'h0000);
      for (int k = 0; k < 50 && issued.size() < 1; k++) cyc();
      if (issued.size() < 1) timeout("stale_fetch");
      else chk("stale_first_addr", {16'd0, issued[0]}, 32'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  clock; all state updates on the rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 redirect  in  1  pulse: discard buffered/in-flight fetches, restart at redirect_addr.
REQ-004 redirect_addr  in  16  new fetch address (jump/branch/return target).
REQ-005 mem_req  out  1  memory read request, held until acknowledged.
REQ-006 mem_addr  out  16  read address; stable while mem_req high.
REQ-007 mem_ack  in  1  one-cycle read completion.
REQ-008 mem_data  in  16  read data; valid only in the mem_ack cycle.
REQ-009 ir_valid  out  1  instruction word available to the decoder.
REQ-010 ir_data  out  16  instruction word at the queue head.
REQ-011 ir_pc  out  16  address of ir_data.
REQ-012 ir_ready  in  1  decoder consumes the head when ir_valid && ir_ready.

Function
REQ-013 The block SHALL hold a 16-bit fetch pointer fpc and an in-order queue of {data, pc} entries, depth D (see Configuration).
REQ-014 FSM states SHALL be IDLE, REQ and DROP.
REQ-015 IDLE->REQ: queue not full, no redirect; mem_req=1, mem_addr=fpc.
REQ-016 REQ on mem_ack: push {mem_data, fpc}; fpc+1 mod 2^16 (0xFFFF wraps to 0x0000); go to REQ if the queue still has room after the push and pop, else IDLE.
REQ-017 REQ with redirect and no mem_ack: go to DROP; mem_req held with the old mem_addr.
REQ-018 DROP on mem_ack: discard mem_data, go to IDLE.
REQ-019 redirect SHALL flush the queue and set fpc=redirect_addr in the same edge, in any state.
REQ-020 redirect coinciding with mem_ack: returned data discarded, no DROP; next state IDLE.
REQ-021 redirect coinciding with an ir pop: flush wins, no separate pop effect.
REQ-022 Latency: ack at cycle M -> ir_valid at M+1 (registered queue, no bypass).
REQ-023 Redirect at cycle N with no request outstanding -> mem_req with mem_addr=redirect_addr at N+1.
REQ-024 Full queue: no new request issued; a pop in the same cycle frees one slot for the next cycle.
REQ-025 Empty queue: ir_valid=0; ir_ready ignored.
REQ-026 mem_ack in IDLE SHALL be ignored.

Reset
REQ-027 rst SHALL force IDLE, fpc=0x0000, empty queue, mem_req=0, mem_addr=0, ir_valid=0, ir_data=0, ir_pc=0.
REQ-028 rst during REQ or DROP: mem_req=0 next cycle; any later stale mem_ack is ignored per REQ-026.
REQ-029 rst SHALL take priority over redirect and mem_ack.

Configuration
REQ-030 SCP_PREFETCH_EN defined: D=4, circular queue with 2-bit pointers plus count.
REQ-031 SCP_PREFETCH_EN undefined: D=1, single holding register; the next fetch issues only after the head is consumed.

Structure
REQ-032 Shared package scp_pkg SHALL hold the word width (16), reset vector (0x0000), prefetch depth constants and the fetch FSM state encoding.
REQ-033 Queue storage SHALL be one sub-module, fetch_queue (push, pop, flush, full, empty, head).

Verification
REQ-034 After rst, mem_ack 1 cycle after each request, ir_ready=1 -> mem_addr 0x0000, 0x0001, 0x0002; ir_data/ir_pc pairs delivered in order.
REQ-035 ir_ready=0 with SCP_PREFETCH_EN -> exactly 4 requests, then mem_req=0; one pop -> one new request.
REQ-036 redirect to 0x1234 while mem_ack is delayed 3 cycles -> old data dropped, next mem_addr=0x1234, ir_pc of the first output=0x1234.
REQ-037 redirect to 0xFFFE -> fetches 0xFFFE, 0xFFFF, 0x0000.
REQ-038 redirect in the same cycle as mem_ack and ir pop -> queue empty next cycle, fetch restarts at the new target.
REQ-039 rst during REQ followed by a stale mem_ack -> no queue entry, ir_valid=0, fetch restarts at 0x0000.
